// File: rtl/execute_md_pkg.sv
// Shared constants for the RV32M multiply/divide execute unit:
// operation and state encodings plus small operand-decode helpers.
package execute_md_pkg;

  // funct3 encoding of the RV32M operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  // Control states of the iterative unit
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Multiply family occupies the lower half of the funct3 space
  function automatic logic isMulOp(input md_op_e op);
    return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU});
  endfunction

  // rs1 is interpreted as two's complement for these operations.
  // MUL is treated as signed: its low product bits are identical either way.
  function automatic logic rs1Signed(input md_op_e op);
    return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  endfunction

  // rs2 is interpreted as two's complement for these operations
  function automatic logic rs2Signed(input md_op_e op);
    return (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  endfunction

  // Remainders follow the dividend sign instead of the quotient sign
  function automatic logic isRemOp(input md_op_e op);
    return (op inside {OP_REM, OP_REMU});
  endfunction

endpackage

// File: rtl/execute_md_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and record the
// quotient bit. Purely combinational, DWIDTH-generic.
module md_div_step #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] rem_i,
  input  logic [DWIDTH-1:0] quo_i,
  input  logic [DWIDTH-1:0] divisor_i,
  output logic [DWIDTH-1:0] rem_o,
  output logic [DWIDTH-1:0] quo_o
);

  logic [DWIDTH:0] shifted;
  logic [DWIDTH:0] trial;

  // The partial remainder is always below the divisor, so the shifted value
  // is below twice the divisor and the top bit of the trial difference is a
  // reliable borrow flag.
  always_comb begin
    shifted = {rem_i, quo_i[DWIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (!trial[DWIDTH]) begin
      rem_o = trial[DWIDTH-1:0];
      quo_o = {quo_i[DWIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[DWIDTH-1:0];
      quo_o = {quo_i[DWIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/execute_md.sv
// RV32M multiply/divide execute unit. Operands are reduced to magnitudes on
// acceptance, a shared hi/lo accumulator runs shift-add multiplication or
// restoring division one bit per cycle, and the sign is re-applied when the
// result is presented in DONE. Division by zero and signed overflow skip the
// iteration entirely.
module execute_md
  import execute_md_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int FAST_MUL = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              divzero_o
);

  localparam int CW = $clog2(DWIDTH + 1);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] hi_q, hi_d;
  logic [DWIDTH-1:0] lo_q, lo_d;
  logic [DWIDTH-1:0] opB_q, opB_d;
  logic              neg_q, neg_d;
  logic              divzero_q, divzero_d;

  md_op_e              opIn;
  logic                signA, signB;
  logic [DWIDTH-1:0]   absA, absB;
  logic                divByZero, divOverflow, mulIn, negIn, accept;
  logic [2*DWIDTH-1:0] fastProd;
  logic [DWIDTH:0]     mulSum;
  logic [DWIDTH-1:0]   divRem, divQuo;
  logic [2*DWIDTH-1:0] prodSigned;
  logic [DWIDTH-1:0]   quoSigned, remSigned, resSel;

  md_div_step #(.DWIDTH(DWIDTH)) u_div_step (
    .rem_i     (hi_q),
    .quo_i     (lo_q),
    .divisor_i (opB_q),
    .rem_o     (divRem),
    .quo_o     (divQuo)
  );

  // Decode the incoming request: magnitudes, result sign and the
  // special division cases that bypass iteration.
  always_comb begin
    opIn        = md_op_e'(funct3_i);
    signA       = rs1Signed(opIn) && rs1_i[DWIDTH-1];
    signB       = rs2Signed(opIn) && rs2_i[DWIDTH-1];
    absA        = signA ? -rs1_i : rs1_i;
    absB        = signB ? -rs2_i : rs2_i;
    mulIn       = isMulOp(opIn);
    negIn       = isRemOp(opIn) ? signA : (signA ^ signB);
    divByZero   = (rs2_i == '0);
    divOverflow = (opIn inside {OP_DIV, OP_REM}) &&
                  (rs1_i == {1'b1, {(DWIDTH-1){1'b0}}}) &&
                  (rs2_i == {DWIDTH{1'b1}});
    fastProd    = {{DWIDTH{1'b0}}, absA} * {{DWIDTH{1'b0}}, absB};
    accept      = valid_i && (state_q == ST_IDLE);
  end

  // Control FSM: next state and handshake outputs; flush wins over
  // both acceptance and retirement.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          if (mulIn) begin
            state_d = (FAST_MUL != 0) ? ST_DONE : ST_MUL;
          end else if (divByZero || divOverflow) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d = ST_IDLE;
    end
  end

  // Datapath next-state: operand load on acceptance, then one shift-add or
  // restoring-subtract step per cycle on the shared hi/lo accumulator.
  always_comb begin
    op_d      = op_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opB_d     = opB_q;
    neg_d     = neg_q;
    divzero_d = divzero_q;
    mulSum    = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opB_q : {DWIDTH{1'b0}})};
    if (accept) begin
      op_d      = opIn;
      cnt_d     = CW'(DWIDTH);
      opB_d     = absB;
      neg_d     = negIn;
      divzero_d = 1'b0;
      hi_d      = '0;
      lo_d      = absA;
      if (mulIn) begin
        if (FAST_MUL != 0) begin
          hi_d = fastProd[2*DWIDTH-1:DWIDTH];
          lo_d = fastProd[DWIDTH-1:0];
        end
      end else if (divByZero) begin
        divzero_d = 1'b1;
        neg_d     = 1'b0;
        hi_d      = rs1_i;
        lo_d      = {DWIDTH{1'b1}};
      end else if (divOverflow) begin
        neg_d = 1'b0;
        hi_d  = '0;
        lo_d  = rs1_i;
      end
    end else if (state_q == ST_MUL) begin
      cnt_d = cnt_q - CW'(1);
      hi_d  = mulSum[DWIDTH:1];
      lo_d  = {mulSum[0], lo_q[DWIDTH-1:1]};
    end else if (state_q == ST_DIV) begin
      cnt_d = cnt_q - CW'(1);
      hi_d  = divRem;
      lo_d  = divQuo;
    end
  end

  // Result selection: re-apply the sign to the magnitude result and expose
  // it only while the unit sits in DONE.
  always_comb begin
    prodSigned = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quoSigned  = neg_q ? -lo_q : lo_q;
    remSigned  = neg_q ? -hi_q : hi_q;
    case (op_q)
      OP_MUL:                       resSel = prodSigned[DWIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: resSel = prodSigned[2*DWIDTH-1:DWIDTH];
      OP_DIV, OP_DIVU:              resSel = quoSigned;
      default:                      resSel = remSigned;
    endcase
    res_o     = (state_q == ST_DONE) ? resSel : '0;
    divzero_o = (state_q == ST_DONE) && divzero_q;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset clears the counter and every operand/result bit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opB_q     <= '0;
      neg_q     <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opB_q     <= opB_d;
      neg_q     <= neg_d;
      divzero_q <= divzero_d;
    end
  end

endmodule

// File: doc/execute_md.md
EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 Parameter DWIDTH, default 32, SHALL set the operand and result width in bits; the legal range is 8 to 64.
REQ-002 Parameter FAST_MUL, default 0, SHALL make MUL/MULH/MULHSU/MULHU single-iteration when set to 1, and iterative when set to 0.
REQ-003 Port clk, input, 1, SHALL be the single clock; every state change occurs on its rising edge.
REQ-004 Port reset_n, input, 1, SHALL be the synchronous, active-low reset.
REQ-005 Ports:
- valid_i, input, 1: request valid.
- ready_o, output, 1: unit can accept.
- funct3_i, input, 3: RV32M operation.
- rs1_i, input, DWIDTH: dividend or multiplicand.
- rs2_i, input, DWIDTH: divisor or multiplier.
- flush_i, input, 1: abort the operation in flight.
- valid_o, output, 1: result valid.
- ready_i, input, 1: consumer accepts the result.
- res_o, output, DWIDTH: result.
- divzero_o, output, 1: the current result came from division by zero.

Function
REQ-006 funct3_i SHALL decode as:
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-007 The state machine SHALL have the states IDLE, MUL, DIV and DONE.
REQ-008 ready_o SHALL be 1 only in IDLE; a request is accepted on an edge where valid_i and ready_o are both 1.
REQ-009 On acceptance, the unit SHALL register operands and funct3, and SHALL take the absolute values of signed operands.
REQ-010 On acceptance, the unit SHALL load a down-counter with DWIDTH and enter MUL or DIV.
REQ-011 MUL and DIV SHALL perform one shift-add or restoring-subtract step per cycle, decrementing the counter.
REQ-012 When the counter reaches 1, the unit SHALL go to DONE, so valid_o rises DWIDTH+1 cycles after the acceptance edge.
REQ-013 With FAST_MUL=1, multiply ops SHALL go straight from IDLE to DONE, with valid_o 1 cycle after acceptance.
REQ-014 The full product SHALL be 2*DWIDTH bits.
REQ-015 MUL SHALL return the low DWIDTH bits of the product; MULH, MULHSU and MULHU SHALL return the high DWIDTH bits.
REQ-016 Signedness SHALL be: MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned x unsigned.
REQ-017 A signed result SHALL be negated when the operand signs differ; a signed remainder SHALL take the sign of the dividend.
REQ-018 A divisor of 0 SHALL bypass iteration and reach DONE in 1 cycle with the following results, and with divzero_o=1:
- DIV/DIVU: all-ones.
- REM/REMU: rs1.
REQ-019 Signed overflow (DIV/REM with rs1 = most-negative and rs2 = -1) SHALL reach DONE in 1 cycle with these results:
- DIV: rs1.
- REM: 0.
REQ-020 In DONE, valid_o=1 and res_o and divzero_o SHALL hold stable until an edge with ready_i=1, which returns the unit to IDLE.
REQ-021 valid_o and ready_o SHALL never both be 1; a new request cannot be accepted on the same edge that retires a result.
REQ-022 flush_i=1 SHALL force IDLE on the next edge from any state, discarding the result.
REQ-023 flush_i SHALL override both acceptance and retirement on the same edge.
REQ-024 Outside DONE, res_o SHALL be 0 and divzero_o SHALL be 0.

Reset
REQ-025 reset_n=0 on an edge SHALL force IDLE and clear the counter and all datapath registers.
REQ-026 After reset, outputs SHALL be ready_o=1, valid_o=0, res_o=0 and divzero_o=0.
REQ-027 A reset during MUL, DIV or DONE SHALL abandon the operation, and no valid_o SHALL follow.

Structure
REQ-028 The operation enum (md_op_e, 8 values) and the state enum (md_state_e) SHALL live in the shared constants package.
REQ-029 The restoring divider step (remainder/quotient update, DWIDTH-generic) SHALL be a sub-module named md_div_step.
REQ-030 Sign handling and result selection SHALL stay in execute_md.

Verification (DWIDTH=32)
REQ-031 MUL with rs1=7, rs2=0xFFFFFFFD (FAST_MUL=0) -> res_o=0xFFFFFFEB with valid_o 33 cycles after acceptance; with FAST_MUL=1, valid_o 1 cycle after acceptance.
REQ-032 MULHU with rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU with rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 DIV 5/0 -> 0xFFFFFFFF with divzero_o=1, 1-cycle latency; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-035 Hold ready_i=0 for 5 cycles in DONE -> res_o stays stable and ready_o stays 0; ready_i=1 -> IDLE next cycle, with a new request accepted one cycle later.
REQ-036 Assert flush_i at iteration 10, and separately reset_n=0 at iteration 20 -> IDLE next edge, no valid_o pulse, ready_o=1.
